// File: rtl/pin_in_filter.sv
// Pin input conditioning: synchroniser, glitch filter, edge detect, sticky interrupt state.
// Ports: clk_i/rst_i (async active-high), pins_i raw pins, filter_en_i, intr_en_rise_i,
//   intr_en_fall_i, intr_clr_i -> pins_o filtered value, rise_o/fall_o edge pulses,
//   intr_state_o sticky state, edge_cnt_o per-pin 8-bit edge counts.
// Optional: define PIN_IN_FILTER_EDGE_CNT_EN to build the saturating edge counters.
module pin_in_filter #(
  parameter int unsigned Width        = 1,
  parameter int unsigned SyncStages   = 2,
  parameter int unsigned FilterCycles = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [Width-1:0]   pins_i,
  input  logic [Width-1:0]   filter_en_i,
  input  logic [Width-1:0]   intr_en_rise_i,
  input  logic [Width-1:0]   intr_en_fall_i,
  input  logic [Width-1:0]   intr_clr_i,
  output logic [Width-1:0]   pins_o,
  output logic [Width-1:0]   rise_o,
  output logic [Width-1:0]   fall_o,
  output logic [Width-1:0]   intr_state_o,
  output logic [8*Width-1:0] edge_cnt_o
);

  localparam int unsigned CW = $clog2(FilterCycles + 1);
  localparam logic [CW-1:0] CntMax = CW'(FilterCycles - 1);

  logic [SyncStages-1:0][Width-1:0] sync_q;
  logic [Width-1:0]                 s;

  logic [Width-1:0][CW-1:0] cnt_q, cnt_d;
  logic [Width-1:0]         filt_q, filt_d;
  logic [Width-1:0]         prev_q;
  logic [Width-1:0]         intr_q, intr_d;
  logic [Width-1:0]         set;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pins_i;
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SyncStages-1];

  // A new value is accepted only after it has differed from the
  // current one for FilterCycles consecutive edges.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < Width; i++) begin
      if (!filter_en_i[i]) begin
        filt_d[i] = s[i];
      end else if (s[i] != filt_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          filt_d[i] = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      filt_q <= '0;
      prev_q <= '0;
      intr_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      prev_q <= filt_q;
      intr_q <= intr_d;
    end
  end

  assign rise_o = filt_q & ~prev_q;
  assign fall_o = ~filt_q & prev_q;

  // Set has priority over a simultaneous clear.
  assign set    = (rise_o & intr_en_rise_i) | (fall_o & intr_en_fall_i);
  assign intr_d = set | (intr_q & ~intr_clr_i);

  assign pins_o       = filt_q;
  assign intr_state_o = intr_q;

`ifdef PIN_IN_FILTER_EDGE_CNT_EN
  logic [Width-1:0][7:0] ecnt_q, ecnt_d;
  logic [Width-1:0]      edge_hit;

  assign edge_hit = rise_o | fall_o;

  // Clear together with an edge counts that edge.
  always_comb begin
    ecnt_d = ecnt_q;
    for (int i = 0; i < Width; i++) begin
      if (intr_clr_i[i]) begin
        ecnt_d[i] = edge_hit[i] ? 8'd1 : 8'd0;
      end else if (edge_hit[i] && ecnt_q[i] != 8'hFF) begin
        ecnt_d[i] = ecnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign edge_cnt_o = ecnt_q;
`else
  assign edge_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pin_in_filter.sv
// Directed bench for pin_in_filter (Width=4, SyncStages=2, FilterCycles=4).
// Expected values are hand-derived from the pin latencies and edge rules.
module tb_pin_in_filter;

`ifdef PIN_IN_FILTER_EDGE_CNT_EN
  localparam bit CntEn = 1'b1;
`else
  localparam bit CntEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  pins, fen, en_r, en_f, clr;
  logic [3:0]  pins_o, rise_o, fall_o, intr_o;
  logic [31:0] ecnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pin_in_filter #(
    .Width(4), .SyncStages(2), .FilterCycles(4)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pins_i        (pins),
    .filter_en_i   (fen),
    .intr_en_rise_i(en_r),
    .intr_en_fall_i(en_f),
    .intr_clr_i    (clr),
    .pins_o        (pins_o),
    .rise_o        (rise_o),
    .fall_o        (fall_o),
    .intr_state_o  (intr_o),
    .edge_cnt_o    (ecnt_o)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic nx(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [3:0] seen;

  initial begin
    rst  = 1'b1;
    pins = '0; fen = '0; en_r = '0; en_f = '0; clr = '0;
    #1;
    chk("rst_pins", {28'd0, pins_o}, 32'd0);
    chk("rst_intr", {28'd0, intr_o}, 32'd0);
    chk("rst_ecnt", ecnt_o, 32'd0);
    nx(2);
    rst = 1'b0;
    nx(2);

    // 1: filtered rise on pin 0, 6 edges latency
    fen = 4'hF; en_r = 4'h1;
    pins[0] = 1'b1;
    nx(5);
    chk("t1_pre", {31'd0, pins_o[0]}, 32'd0);
    nx(1);
    chk("t1_pin", {31'd0, pins_o[0]}, 32'd1);
    chk("t1_rise", {31'd0, rise_o[0]}, 32'd1);
    chk("t1_intr0", {31'd0, intr_o[0]}, 32'd0);
    nx(1);
    chk("t1_rise_off", {31'd0, rise_o[0]}, 32'd0);
    chk("t1_intr1", {31'd0, intr_o[0]}, 32'd1);

    // 2: 3-cycle glitch on pin 1 is rejected
    pins[1] = 1'b1;
    nx(3);
    pins[1] = 1'b0;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      nx(1);
      seen[0] = seen[0] | pins_o[1];
      seen[1] = seen[1] | rise_o[1];
      seen[2] = seen[2] | fall_o[1];
    end
    chk("t2_glitch", {28'd0, seen}, 32'd0);

    // 3: unfiltered 1-cycle pulse on pin 2
    fen = 4'h0;
    pins[2] = 1'b1;
    nx(1);
    pins[2] = 1'b0;
    nx(1);
    chk("t3_e2", {31'd0, pins_o[2]}, 32'd0);
    nx(1);
    chk("t3_e3", {29'd0, pins_o[2], rise_o[2], fall_o[2]}, 32'b110);
    nx(1);
    chk("t3_e4", {29'd0, pins_o[2], rise_o[2], fall_o[2]}, 32'b001);
    nx(1);
    chk("t3_e5", {29'd0, pins_o[2], rise_o[2], fall_o[2]}, 32'b000);

    // 4: set beats clear on pin 3
    en_r = 4'h9; en_f = 4'h8;
    pins[3] = 1'b1;
    nx(3);
    chk("t4_rise", {31'd0, rise_o[3]}, 32'd1);
    nx(1);
    chk("t4_intr_set", {31'd0, intr_o[3]}, 32'd1);
    pins[3] = 1'b0;
    nx(3);
    chk("t4_fall", {31'd0, fall_o[3]}, 32'd1);
    clr = 4'h8;
    nx(1);
    chk("t4_set_wins", {31'd0, intr_o[3]}, 32'd1);
    chk("t4_ecnt_ld1", {24'd0, ecnt_o[31:24]}, CntEn ? 32'd1 : 32'd0);
    nx(1);
    clr = 4'h0;
    chk("t4_cleared", {31'd0, intr_o[3]}, 32'd0);
    chk("t4_ecnt_clr", {24'd0, ecnt_o[31:24]}, 32'd0);
    chk("t4_intr0_kept", {31'd0, intr_o[0]}, 32'd1);

    // 5: async reset mid-count on pin 1
    fen = 4'hF;
    pins[1] = 1'b1;
    nx(4);
    #2 rst = 1'b1;
    #1;
    chk("t5_pins", {28'd0, pins_o}, 32'd0);
    chk("t5_edges", {24'd0, rise_o, fall_o}, 32'd0);
    chk("t5_intr", {28'd0, intr_o}, 32'd0);
    chk("t5_ecnt", ecnt_o, 32'd0);
    pins = '0;
    nx(2);
    rst = 1'b0;
    seen = '0;
    for (int i = 0; i < 12; i++) begin
      nx(1);
      seen = seen | pins_o | rise_o | fall_o | intr_o;
    end
    chk("t5_quiet", {28'd0, seen}, 32'd0);

    // 6: edge counter saturation on pin 0
    fen = 4'h0; en_r = '0; en_f = '0;
    for (int i = 0; i < 10; i++) begin
      pins[0] = ~pins[0];
      nx(1);
    end
    nx(5);
    chk("t6_cnt10", {24'd0, ecnt_o[7:0]}, CntEn ? 32'd10 : 32'd0);
    for (int i = 0; i < 290; i++) begin
      pins[0] = ~pins[0];
      nx(1);
    end
    nx(5);
    chk("t6_sat", {24'd0, ecnt_o[7:0]}, CntEn ? 32'd255 : 32'd0);
    chk("t6_other", {8'd0, ecnt_o[31:8]}, 32'd0);
    clr = 4'h1;
    nx(1);
    clr = 4'h0;
    chk("t6_clr", {24'd0, ecnt_o[7:0]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
